dmem_access_unit: RTL and testbench

//  Load/store unit between the core's ALU result / register read port and a handshaked word-wide data memory.

---
 rtl/dmem_access_unit.sv | 128 ++++++++++++
 tb/tb_dmem_access_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Load/store unit between the core and a handshaked word-wide data memory.
// Decodes funct3 into lane enables and load extension, and stalls the core until the memory acks or times out.
module dmem_access_unit #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [2:0]        funct3_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              misalign_o,
    output logic              timeout_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);
    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       lat_f3;
    logic [1:0]       lat_lo;

    logic        req;
    logic        aligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_rep;
    logic [15:0] lane;
    logic [31:0] load_ext;

    // Address bits above the word index wrap and are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:ADDR_W+2];

    // Request decode: size from funct3[1:0], lane enables and replicated store data.
    always_comb begin
        req       = rd_i | wr_i;
        aligned   = 1'b1;
        be_c      = 4'b1111;
        wdata_rep = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_c      = 4'b0001 << addr_i[1:0];
                wdata_rep = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr_i[0];
                be_c      = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_i[15:0]}};
            end
            default: aligned = (addr_i[1:0] == 2'b00);
        endcase
    end

    // Lane select and sign/zero extension of the returned word.
    always_comb begin
        lane     = 16'(mem_rdata_i >> {lat_lo, 3'b000});
        load_ext = mem_rdata_i;
        case (lat_f3[1:0])
            2'b00:   load_ext = lat_f3[2] ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_ext = lat_f3[2] ? {16'd0, lane} : {{16{lane[15]}}, lane};
            default: load_ext = mem_rdata_i;
        endcase
    end

    assign stall_o    = (state == S_WAIT) || ((state == S_IDLE) && req && aligned);
    assign misalign_o = (state == S_IDLE) && req && !aligned;
    assign timeout_o  = (state == S_WAIT) && !mem_ack_i && (cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_f3      <= '0;
            lat_lo      <= '0;
            rdata_o     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && aligned) begin
                        mem_we_o    <= wr_i;
                        mem_addr_o  <= addr_i[ADDR_W+1:2];
                        mem_be_o    <= be_c;
                        mem_wdata_o <= wdata_rep;
                        lat_f3      <= funct3_i;
                        lat_lo      <= addr_i[1:0];
                        cnt         <= '0;
                        mem_req_o   <= 1'b1;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An ack in the final cycle takes priority over the timeout.
                    if (mem_ack_i) begin
                        rdata_o   <= load_ext;
                        mem_req_o <= 1'b0;
                        state     <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata_o   <= '0;
                        mem_req_o <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed spec scenarios then random loads/stores
// against a byte-level memory model with configurable ack latency.
module tb_dmem_access_unit;
    localparam int unsigned ADDR_W = 10;
    localparam int          TO     = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              rd_i = 1'b0;
    logic              wr_i = 1'b0;
    logic [31:0]       addr_i = '0;
    logic [31:0]       wdata_i = '0;
    logic [2:0]        funct3_i = '0;
    logic              stall_o;
    logic [31:0]       rdata_o;
    logic              misalign_o;
    logic              timeout_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_ack_i = 1'b0;
    logic [31:0]       mem_rdata_i = '0;

    int tests = 0;
    int fails = 0;
    logic [31:0] mem [1024];

    dmem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rd_i(rd_i), .wr_i(wr_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .funct3_i(funct3_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
        .timeout_o(timeout_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    // Reference load: pick n bytes at the byte offset, then extend arithmetically.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int n = size_of(f3);
        longint off = longint'(a[1:0]);
        longint v = (longint'(w) >> (8 * off)) & ((64'sd1 << (8 * n)) - 1);
        if (n < 4 && f3[2] == 1'b0 && v >= (64'sd1 << (8 * n - 1)))
            v = v - (64'sd1 << (8 * n));
        return 32'(v);
    endfunction

    // One access starting at posedge+1 in IDLE; k = WAIT cycle carrying the ack, 0 = never.
    task automatic do_access(input bit rdv, input bit wrv, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int k);
        int n, off, stalls, last;
        bit acked;
        logic [31:0] exp_be, exp_wd, word, exp_rd, w;
        n = size_of(f3);
        off = int'(a[1:0]);
        word = '0;
        rd_i = rdv; wr_i = wrv; addr_i = a; wdata_i = wd; funct3_i = f3;
        #1;
        if ((off % n) != 0) begin
            chk("misalign_pulse", 32'(misalign_o), 32'd1);
            chk("misalign_stall", 32'(stall_o), 32'd0);
            rd_i = 1'b0; wr_i = 1'b0;
            @(posedge clk_i); #1;
            chk("misalign_no_req", 32'(mem_req_o), 32'd0);
            chk("misalign_one_cycle", 32'(misalign_o), 32'd0);
            return;
        end
        chk("req_stall", 32'(stall_o), 32'd1);
        chk("req_no_misalign", 32'(misalign_o), 32'd0);
        stalls = 1;
        exp_be = '0;
        for (int i = 0; i < n; i++) exp_be[off + i] = 1'b1;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
        acked = (k >= 1 && k <= TO);
        last = acked ? k : TO;
        @(posedge clk_i); #1;
        chk("mem_req", 32'(mem_req_o), 32'd1);
        chk("mem_we", 32'(mem_we_o), 32'(wrv));
        chk("mem_addr", 32'(mem_addr_o), 32'(a[11:2]));
        chk("mem_be", 32'(mem_be_o), exp_be);
        if (wrv) chk("mem_wdata", mem_wdata_o, exp_wd);
        for (int j = 1; j <= last; j++) begin
            if (j == k) begin
                word = wrv ? $urandom : mem[a[11:2]];
                mem_rdata_i = word;
                mem_ack_i = 1'b1;
            end else begin
                mem_rdata_i = $urandom;
                mem_ack_i = 1'b0;
            end
            #1;
            stalls += int'(stall_o);
            chk("timeout_pulse", 32'(timeout_o), 32'(!acked && j == TO));
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
        end
        exp_rd = acked ? model_load(f3, a, word) : 32'd0;
        if (wrv && acked) begin
            w = mem[a[11:2]];
            for (int i = 0; i < n; i++) w[8*(off + i) +: 8] = wd[8*i +: 8];
            mem[a[11:2]] = w;
        end
        chk("stall_cycles", 32'(stalls), 32'(last + 1));
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("done_req", 32'(mem_req_o), 32'd0);
        chk("done_rdata", rdata_o, exp_rd);
        rd_i = 1'b0; wr_i = 1'b0;
        @(posedge clk_i); #1;
        chk("idle_stall", 32'(stall_o), 32'd0);
        chk("idle_rdata_hold", rdata_o, exp_rd);
    endtask

    initial begin
        logic [31:0] a;
        bit wrv;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Directed scenarios
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2);
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'h80FF0000, 1);
        do_access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 3);
        chk("lb_sign", rdata_o, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1);
        chk("lbu_zero", rdata_o, 32'h00000080);
        do_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000ABCD, 2);
        do_access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 2);
        chk("lhu_val", rdata_o, 32'h0000ABCD);
        do_access(1'b1, 1'b0, 3'b010, 32'h0E, 32'h0, 1);
        do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0);
        do_access(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, TO);
        do_access(1'b1, 1'b1, 3'b000, 32'hFFFF_F011, 32'h5A, 1);
        do_access(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 1);
        chk("wrap_store_lb", rdata_o, 32'h0000005A);

        // Reset while waiting on the memory
        rd_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h30;
        @(posedge clk_i); #1;
        chk("prerst_req", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1; rd_i = 1'b0;
        @(posedge clk_i); #1;
        chk("wait_rst_req", 32'(mem_req_o), 32'd0);
        chk("wait_rst_stall", 32'(stall_o), 32'd0);
        chk("wait_rst_rdata", rdata_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Random mix of loads and stores over a small wrapped region
        for (int t = 0; t < 60; t++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            wrv = ($urandom_range(0, 2) == 0);
            do_access(!wrv || ($urandom_range(0, 3) == 0), wrv,
                      wrv ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7)),
                      a, $urandom, $urandom_range(0, TO));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
